// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative generalized shuffle engine.
package alu_pkg;

    localparam int WORD_W = 32;
    localparam int STAGES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gshfl_state_t;

    // Stage k moves field bits left (L) or right (R) by N = 2^k.
    localparam logic [WORD_W-1:0] MASK_L_N1 = 32'h4444_4444;
    localparam logic [WORD_W-1:0] MASK_R_N1 = 32'h2222_2222;
    localparam logic [WORD_W-1:0] MASK_L_N2 = 32'h3030_3030;
    localparam logic [WORD_W-1:0] MASK_R_N2 = 32'h0C0C_0C0C;
    localparam logic [WORD_W-1:0] MASK_L_N4 = 32'h0F00_0F00;
    localparam logic [WORD_W-1:0] MASK_R_N4 = 32'h00F0_00F0;
    localparam logic [WORD_W-1:0] MASK_L_N8 = 32'h00FF_0000;
    localparam logic [WORD_W-1:0] MASK_R_N8 = 32'h0000_FF00;

    function automatic logic [WORD_W-1:0] stage_mask_l(input logic [1:0] idx);
        case (idx)
            2'd0:    return MASK_L_N1;
            2'd1:    return MASK_L_N2;
            2'd2:    return MASK_L_N4;
            default: return MASK_L_N8;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] stage_mask_r(input logic [1:0] idx);
        case (idx)
            2'd0:    return MASK_R_N1;
            2'd1:    return MASK_R_N2;
            2'd2:    return MASK_R_N4;
            default: return MASK_R_N8;
        endcase
    endfunction

endpackage

// File: rtl/alu_gshfl_stage.sv
// One butterfly stage: swaps the two middle N-bit fields of every 4N-bit block.
module alu_gshfl_stage
    import alu_pkg::*;
(
    input  logic [WORD_W-1:0] i_data,
    input  logic [1:0]        i_idx,
    input  logic              i_en,
    output logic [WORD_W-1:0] o_data
);

    logic [WORD_W-1:0] w_l;
    logic [WORD_W-1:0] w_r;
    logic [WORD_W-1:0] w_swapped;
    logic [4:0]        w_shift;

    assign w_l       = stage_mask_l(i_idx);
    assign w_r       = stage_mask_r(i_idx);
    assign w_shift   = 5'd1 << i_idx;
    assign w_swapped = (i_data & ~(w_l | w_r))
                     | ((i_data << w_shift) & w_l)
                     | ((i_data >> w_shift) & w_r);
    assign o_data    = i_en ? w_swapped : i_data;

endmodule

// File: rtl/alu_gshfl_iter.sv
// Iterative shuffle/unshuffle engine, one butterfly stage per clock.
// Define ALU_GSHFL_SKIP_EN to visit only enabled stages (latency 1 + popcount(ctl)).
module alu_gshfl_iter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        in_ctl,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    if (DATA_W != 32) begin : g_bad_width
        $error("alu_gshfl_iter supports only DATA_W = 32");
    end

    gshfl_state_t      r_state;
    gshfl_state_t      w_state_next;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_ctl;
    logic              r_mode;
    logic [1:0]        r_cnt;
    logic [1:0]        w_idx;
    logic              w_en;
    logic              w_last;
    logic              w_start_done;
    logic [DATA_W-1:0] w_stage_out;

`ifdef ALU_GSHFL_SKIP_EN
    // r_ctl holds the stages still to visit; shuffle takes the highest, unshuffle the lowest.
    always_comb begin
        w_idx = 2'd0;
        if (r_mode) begin
            for (int k = 3; k >= 0; k--) begin
                if (r_ctl[k]) w_idx = 2'(k);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (r_ctl[k]) w_idx = 2'(k);
            end
        end
    end
    assign w_en         = 1'b1;
    assign w_last       = (r_ctl & ~(4'b0001 << w_idx)) == 4'b0000;
    assign w_start_done = (in_ctl == 4'b0000);
`else
    assign w_idx        = r_mode ? r_cnt : ~r_cnt;
    assign w_en         = r_ctl[w_idx];
    assign w_last       = (r_cnt == 2'(STAGES - 1));
    assign w_start_done = 1'b0;
`endif

    alu_gshfl_stage u_stage (
        .i_data (r_data),
        .i_idx  (w_idx),
        .i_en   (w_en),
        .o_data (w_stage_out)
    );

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = w_start_done ? DONE : RUN;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (flush) w_state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_ctl   <= '0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_data <= '0;
                r_ctl  <= '0;
                r_mode <= 1'b0;
                r_cnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (in_valid) begin
                            r_data <= in_data;
                            r_ctl  <= in_ctl;
                            r_mode <= in_mode;
                            r_cnt  <= '0;
                        end
                    end
                    RUN: begin
                        r_data <= w_stage_out;
                        r_cnt  <= r_cnt + 2'd1;
`ifdef ALU_GSHFL_SKIP_EN
                        r_ctl  <= r_ctl & ~(4'b0001 << w_idx);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_data = r_data;

endmodule
